ram_access_ctrl: RTL and testbench
==================================

// Module: ram_access_ctrl
// PURPOSE
//  Initiator side of the on-chip RAM port (address/data/wren/q, 32-bit words).
//  Accepts single-word read/write requests from the CPU datapath (MAR/MDR side)
//  over a valid/ready handshake and sequences the RAM's write-enable and
//  read-latency timing. Returns every request as a one-cycle response pulse.
//  Sits between the datapath memory stage and the RAM instance.
// PARAMETERS
//  ADDR_W        8   RAM word-address width (RAM depth = 2**ADDR_W words)
//  DATA_W        32  data word width
//  READ_LATENCY  1   clock edges from the RAM registering the address to q valid (1..3)
// PORTS
//  clock        in   1       system clock, all logic on rising edge
//  reset_n      in   1       synchronous active-low reset
//  req_valid    in   1       request present
//  req_ready    out  1       controller can accept a request this cycle
//  req_we       in   1       1 = write, 0 = read
//  req_addr     in   32      word address from MAR
//  req_wdata    in   DATA_W  write data from MDR
//  resp_valid   out  1       one-cycle response pulse
//  resp_we      out  1       echoes req_we of the completed request
//  resp_err     out  1       address out of range; RAM was not accessed
//  resp_rdata   out  DATA_W  read data; 0 for writes and errors
//  ram_address  out  ADDR_W  to RAM address
//  ram_data     out  DATA_W  to RAM data
//  ram_wren     out  1       to RAM wren
//  ram_q        in   DATA_W  from RAM q
// BEHAVIOUR
//  Reset: state=IDLE. req_ready=1. resp_valid=resp_we=resp_err=0.
//   resp_rdata=0. ram_address=0. ram_data=0. ram_wren=0. Latency counter=0.
//  All outputs are registered. No combinational path from req_* to ram_* or resp_*.
//  States: IDLE, WR, RD, RESP.
//  IDLE: req_ready=1. At an edge with req_valid=1:
//   - Latch req_addr[ADDR_W-1:0] into ram_address and req_wdata into ram_data.
//   - Latch req_we. Load the latency counter with READ_LATENCY.
//   - Go to RESP with err=1 if req_addr[31:ADDR_W]!=0. Otherwise go to WR
//     (req_we=1) or RD (req_we=0).
//  WR: ram_wren=1 for exactly this one cycle, with ram_address and ram_data stable.
//   The next edge goes to RESP.
//  RD: ram_wren=0 and ram_address held. Each edge decrements the counter while
//   it is nonzero. At the edge where the counter is 0, capture ram_q into
//   resp_rdata and go to RESP.
//  RESP: resp_valid=1 for one cycle, with resp_we and resp_err valid.
//   The next edge returns to IDLE. There is no response backpressure.
//  Latency from the accept edge to the resp_valid cycle:
//   - write: 2 cycles
//   - read: READ_LATENCY+2 cycles
//   - error: 1 cycle
//  req_ready is low in WR/RD/RESP. req_valid is ignored outside IDLE, and the
//   requester holds its request until it is accepted. Max rate is one request
//   per 3 cycles for writes.
//  Errors leave ram_wren=0 for the whole request and return resp_rdata=0.
//  resp_rdata holds its last value only through RESP. It is cleared to 0 on the
//   next accept.
//  Reset mid-operation: the reset edge forces IDLE and all outputs to their
//   reset values. A RAM write whose wren was already high at that edge completes
//   in the RAM. No response is issued for the aborted request.
//  Address wrap: ADDR_W=8 gives valid addresses 0x00..0xFF. 0x100 and above are errors.
// TESTING
//  1. Write 0xA5A5A5A5 to 0x00, then read 0x00 -> ram_wren high for exactly
//     1 cycle; write resp 2 cycles after accept; read resp_rdata=0xA5A5A5A5
//     at 3 cycles, err=0.
//  2. Write 0x5A5A5A5A to 0x01, then read 0x00 and 0x01 -> 0xA5A5A5A5 and
//     0x5A5A5A5A (no aliasing).
//  3. Write to 0x100 -> resp_err=1 after 1 cycle; ram_wren never asserted;
//     a later read of 0x00 still returns 0xA5A5A5A5.
//  4. Hold req_valid high across back-to-back reads of 0x00 and 0xFF -> second
//     accept occurs only in IDLE after the first RESP; exactly one resp_valid
//     pulse per request.
//  5. Assert reset_n=0 for 1 cycle during RD -> next cycle IDLE, req_ready=1,
//     resp_rdata=0, no resp_valid pulse; a following read of 0x01 returns
//     0x5A5A5A5A.
//  6. With READ_LATENCY=2, repeat scenario 1 -> read response 4 cycles after
//     accept, data 0xA5A5A5A5.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// Initiator for a single-port synchronous RAM: accepts one read/write request at a
// time over valid/ready, drives wren/address/data and returns a one-cycle response.
module ram_access_ctrl #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_we,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY);

  logic [1:0] state;
  logic [1:0] lat_cnt;
  logic       we_q;
  logic       addr_err;

  // Any address bit above the RAM depth makes the request an error.
  assign addr_err = |req_addr[31:ADDR_W];

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples the pre-edge value of every other register, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      we_q        <= 1'b0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_we     <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
    end else begin
      // Pulse-type outputs default low; the state that wants them raises them.
      resp_valid <= 1'b0;
      resp_we    <= 1'b0;
      resp_err   <= 1'b0;
      ram_wren   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            ram_address <= req_addr[ADDR_W-1:0];
            ram_data    <= req_wdata;
            we_q        <= req_we;
            lat_cnt     <= LAT_INIT;
            resp_rdata  <= '0;
            req_ready   <= 1'b0;
            if (addr_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_we    <= req_we;
              resp_err   <= 1'b1;
            end else if (req_we) begin
              state    <= WR;
              ram_wren <= 1'b1;
            end else begin
              state <= RD;
            end
          end
        end
        WR: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_we    <= we_q;
        end
        RD: begin
          // Counter runs down the RAM read latency before q is sampled.
          if (lat_cnt != 2'd0) begin
            lat_cnt <= lat_cnt - 2'd1;
          end else begin
            resp_rdata <= ram_q;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_we    <= we_q;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl: two instances (read latency 1 and 2), each
// attached to a behavioural synchronous RAM, exercised through a shared request port.
module tb_ram_access_ctrl;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        sel_b;

  logic        req_valid_a, req_ready_a, resp_valid_a, resp_we_a, resp_err_a, ram_wren_a;
  logic [31:0] resp_rdata_a, ram_data_a, ram_q_a;
  logic [7:0]  ram_address_a;
  logic        req_valid_b, req_ready_b, resp_valid_b, resp_we_b, resp_err_b, ram_wren_b;
  logic [31:0] resp_rdata_b, ram_data_b, ram_q_b;
  logic [7:0]  ram_address_b;

  logic        obs_ready, obs_resp_valid, obs_resp_we, obs_resp_err, obs_wren;
  logic [31:0] obs_rdata, obs_ram_data;
  logic [7:0]  obs_ram_address;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;
  int wrens    = 0;

  assign req_valid_a = req_valid & ~sel_b;
  assign req_valid_b = req_valid & sel_b;

  assign obs_ready       = sel_b ? req_ready_b   : req_ready_a;
  assign obs_resp_valid  = sel_b ? resp_valid_b  : resp_valid_a;
  assign obs_resp_we     = sel_b ? resp_we_b     : resp_we_a;
  assign obs_resp_err    = sel_b ? resp_err_b    : resp_err_a;
  assign obs_rdata       = sel_b ? resp_rdata_b  : resp_rdata_a;
  assign obs_wren        = sel_b ? ram_wren_b    : ram_wren_a;
  assign obs_ram_data    = sel_b ? ram_data_b    : ram_data_a;
  assign obs_ram_address = sel_b ? ram_address_b : ram_address_a;

  ram_access_ctrl #(.ADDR_W(8), .DATA_W(32), .READ_LATENCY(1)) dut_a (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a), .resp_we(resp_we_a), .resp_err(resp_err_a),
    .resp_rdata(resp_rdata_a), .ram_address(ram_address_a), .ram_data(ram_data_a),
    .ram_wren(ram_wren_a), .ram_q(ram_q_a)
  );

  ram_access_ctrl #(.ADDR_W(8), .DATA_W(32), .READ_LATENCY(2)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_b), .resp_we(resp_we_b), .resp_err(resp_err_b),
    .resp_rdata(resp_rdata_b), .ram_address(ram_address_b), .ram_data(ram_data_b),
    .ram_wren(ram_wren_b), .ram_q(ram_q_b)
  );

  // RAM models: address registered at the edge, q valid one (a) or two (b) edges later.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] stage_b;

  always @(posedge clock) begin
    if (ram_wren_a) mem_a[ram_address_a] <= ram_data_a;
    ram_q_a <= mem_a[ram_address_a];
    if (ram_wren_b) mem_b[ram_address_b] <= ram_data_b;
    stage_b <= mem_b[ram_address_b];
    ram_q_b <= stage_b;
  end

  always @(negedge clock) begin
    if (obs_resp_valid) pulses <= pulses + 1;
    if (obs_wren)       wrens  <= wrens + 1;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One request from IDLE through response and back to IDLE.
  task automatic transact(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int exp_lat,
                          input logic exp_err, input logic [31:0] exp_rdata);
    int p0;
    int w0;
    int lat;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    check({tag, " ready_before"}, 64'(obs_ready), 64'd1);
    p0 = pulses;
    w0 = wrens;
    step();
    req_valid = 1'b0;
    if (we && !exp_err) begin
      check({tag, " wren_c1"}, 64'(obs_wren), 64'd1);
      check({tag, " ram_addr"}, 64'(obs_ram_address), 64'(addr[7:0]));
      check({tag, " ram_data"}, 64'(obs_ram_data), 64'(wdata));
    end
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      if (obs_resp_valid) begin
        lat = c;
        break;
      end
      step();
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " err"}, 64'(obs_resp_err), 64'(exp_err));
    check({tag, " we"}, 64'(obs_resp_we), 64'(we));
    check({tag, " rdata"}, 64'(obs_rdata), 64'(exp_rdata));
    step();
    check({tag, " ready_after"}, 64'(obs_ready), 64'd1);
    check({tag, " pulses"}, 64'(pulses - p0), 64'd1);
    check({tag, " wren_cycles"}, 64'(wrens - w0), (we && !exp_err) ? 64'd1 : 64'd0);
  endtask

  initial begin
    int p0;
    sel_b     = 1'b0;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    step();
    step();
    check("rst ready", 64'(req_ready_a), 64'd1);
    check("rst resp_valid", 64'(resp_valid_a), 64'd0);
    check("rst resp_we", 64'(resp_we_a), 64'd0);
    check("rst resp_err", 64'(resp_err_a), 64'd0);
    check("rst rdata", 64'(resp_rdata_a), 64'd0);
    check("rst ram_address", 64'(ram_address_a), 64'd0);
    check("rst ram_data", 64'(ram_data_a), 64'd0);
    check("rst wren", 64'(ram_wren_a), 64'd0);
    reset_n = 1'b1;
    step();

    // 1: write then read back
    transact("t1 wr00", 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 2, 1'b0, 32'h0);
    transact("t1 rd00", 1'b0, 32'h0000_0000, 32'h0,        3, 1'b0, 32'hA5A5_A5A5);

    // 2: second location, no aliasing
    transact("t2 wr01", 1'b1, 32'h0000_0001, 32'h5A5A_5A5A, 2, 1'b0, 32'h0);
    transact("t2 rd00", 1'b0, 32'h0000_0000, 32'h0,        3, 1'b0, 32'hA5A5_A5A5);
    transact("t2 rd01", 1'b0, 32'h0000_0001, 32'h0,        3, 1'b0, 32'h5A5A_5A5A);

    // 3: out-of-range addresses
    transact("t3 wr100", 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1, 1'b1, 32'h0);
    transact("t3 rd800", 1'b0, 32'h8000_0000, 32'h0,        1, 1'b1, 32'h0);
    transact("t3 rd00",  1'b0, 32'h0000_0000, 32'h0,        3, 1'b0, 32'hA5A5_A5A5);

    // 4: top address, then valid held high across two reads
    transact("t4 wrFF", 1'b1, 32'h0000_00FF, 32'hCAFE_F00D, 2, 1'b0, 32'h0);
    p0 = pulses;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_valid = 1'b1;
    step();
    req_addr = 32'h0000_00FF;
    check("t4 c1 ready", 64'(req_ready_a), 64'd0);
    step();
    check("t4 c2 ready", 64'(req_ready_a), 64'd0);
    check("t4 c2 valid", 64'(resp_valid_a), 64'd0);
    step();
    check("t4 c3 valid", 64'(resp_valid_a), 64'd1);
    check("t4 c3 rdata", 64'(resp_rdata_a), 64'hA5A5_A5A5);
    check("t4 c3 ready", 64'(req_ready_a), 64'd0);
    step();
    check("t4 c4 valid", 64'(resp_valid_a), 64'd0);
    check("t4 c4 ready", 64'(req_ready_a), 64'd1);
    step();
    req_valid = 1'b0;
    check("t4 c5 ready", 64'(req_ready_a), 64'd0);
    check("t4 c5 rdata_clr", 64'(resp_rdata_a), 64'd0);
    step();
    check("t4 c6 valid", 64'(resp_valid_a), 64'd0);
    step();
    check("t4 c7 valid", 64'(resp_valid_a), 64'd1);
    check("t4 c7 rdata", 64'(resp_rdata_a), 64'hCAFE_F00D);
    step();
    check("t4 pulses", 64'(pulses - p0), 64'd2);
    check("t4 c8 ready", 64'(req_ready_a), 64'd1);

    // 5: reset during a read
    req_we    = 1'b0;
    req_addr  = 32'h0000_0001;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check("t5 in_rd ready", 64'(req_ready_a), 64'd0);
    reset_n = 1'b0;
    p0 = pulses;
    step();
    reset_n = 1'b1;
    check("t5 ready", 64'(req_ready_a), 64'd1);
    check("t5 rdata", 64'(resp_rdata_a), 64'd0);
    check("t5 valid", 64'(resp_valid_a), 64'd0);
    step();
    step();
    step();
    step();
    check("t5 no_pulse", 64'(pulses - p0), 64'd0);
    transact("t5 rd01", 1'b0, 32'h0000_0001, 32'h0, 3, 1'b0, 32'h5A5A_5A5A);

    // 6: read latency 2 instance
    sel_b = 1'b1;
    step();
    transact("t6 wr00", 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 2, 1'b0, 32'h0);
    transact("t6 rd00", 1'b0, 32'h0000_0000, 32'h0,        4, 1'b0, 32'hA5A5_A5A5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
